ex_mdu: RTL

//  EX-stage multiply/divide unit; consumes operands and decoded op read from the ID/EX pipeline register.

---
 rtl/ex_mdu.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit with architectural HI/LO.
// Result is computed at issue and committed after a fixed busy window.
module ex_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] rdata_o
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] MUL_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   sh_hi_q, sh_hi_d;
  logic [31:0]   sh_lo_q, sh_lo_d;
  logic          sh_we_q, sh_we_d;

  logic [31:0]        res_hi, res_lo;
  logic               res_we;
  logic signed [63:0] sprod;
  logic [63:0]        uprod;
  logic signed [31:0] sa, sb, sq, sr;
  logic [31:0]        ub, uq, ur;
  logic               ovf;

  always_comb begin
    sprod = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    uprod = {32'd0, a_i} * {32'd0, b_i};
    // Substitute a divisor of 1 so a zero divisor never yields X
    ub  = (b_i == 32'd0) ? 32'd1 : b_i;
    sa  = $signed(a_i);
    sb  = $signed(ub);
    ovf = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    sq  = ovf ? $signed(32'h8000_0000) : sa / sb;
    sr  = ovf ? 32'sd0 : sa % sb;
    uq  = a_i / ub;
    ur  = a_i % ub;
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_we = 1'b1;
    case (op_i)
      OP_MULT: begin
        res_hi = sprod[63:32];
        res_lo = sprod[31:0];
      end
      OP_MULTU: begin
        res_hi = uprod[63:32];
        res_lo = uprod[31:0];
      end
      OP_DIV: begin
        res_hi = sr;
        res_lo = sq;
        res_we = (b_i != 32'd0);
      end
      OP_DIVU: begin
        res_hi = ur;
        res_lo = uq;
        res_we = (b_i != 32'd0);
      end
      default: res_we = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    sh_we_d = sh_we_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          case (op_i)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d = RUN;
              cnt_d   = op_i[1] ? DIV_N : MUL_N;
              sh_hi_d = res_hi;
              sh_lo_d = res_lo;
              sh_we_d = res_we;
            end
            OP_MTHI: hi_d = a_i;
            OP_MTLO: lo_d = a_i;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (sh_we_q) begin
            hi_d = sh_hi_q;
            lo_d = sh_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
      sh_we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      sh_we_q <= sh_we_d;
    end
  end

  assign busy_o  = (state_q == RUN);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign rdata_o = (op_i == OP_MFHI) ? hi_q :
                   (op_i == OP_MFLO) ? lo_q : 32'd0;

endmodule
